// File: rtl/regwrite_scheduler.sv
// Register-file write-port scheduler for the multicycle MIPS datapath.
// Round-robin arbitration picks one writeback requester per cycle; the
// chosen mux select, destination index and write strobe appear one cycle
// after the grant. Writes to $zero and illegal select codes still complete
// the handshake but never strobe the register file.
module regwrite_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 4,
    parameter int SEL_MAX = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [5*NUM_REQ-1:0]     req_dest,
    input  logic [SEL_W*NUM_REQ-1:0] req_sel,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [SEL_W-1:0]         mem_to_reg,
    output logic [4:0]               write_reg,
    output logic                     reg_write,
    output logic                     sel_err,
    output logic [15:0]              write_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [SEL_W-1:0] SEL_LIMIT = SEL_W'(SEL_MAX);

    // FSM encoding: WRITE means the registered outputs hold a fresh grant.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] rr_ptr;

    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand;

    logic [4:0]       dest_arr [NUM_REQ];
    logic [SEL_W-1:0] sel_arr  [NUM_REQ];
    logic [4:0]       grant_dest;
    logic [SEL_W-1:0] grant_sel;
    logic             sel_bad;
    logic             commit;

    // Registered qualifiers of the last grant, gated by the WRITE state.
    logic             commit_q;
    logic             sel_bad_q;

    // Split the flat request buses into per-requester fields.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign dest_arr[i] = req_dest[5*i +: 5];
        assign sel_arr[i]  = req_sel[SEL_W*i +: SEL_W];
    end

    // Round-robin search from rr_ptr upward; blocked by reset or stall.
    // The grant is built from req_valid only, so req_dest/req_sel never
    // reach req_grant combinationally.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the block leaves one unassigned and no latch appears.
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_grant = '0;
        if (!reset && !stall) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (grant_any) begin
            req_grant[grant_idx] = 1'b1;
        end
    end

    assign grant_dest = dest_arr[grant_idx];
    assign grant_sel  = sel_arr[grant_idx];
    assign sel_bad    = (grant_sel > SEL_LIMIT);
    assign commit     = (grant_dest != 5'd0) && !sel_bad;

    // Register the granted write, advance the pointer and count commits.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register here
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            mem_to_reg  <= '0;
            write_reg   <= '0;
            commit_q    <= 1'b0;
            sel_bad_q   <= 1'b0;
            write_count <= '0;
        end else if (grant_any) begin
            state      <= WRITE;
            rr_ptr     <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
            mem_to_reg <= grant_sel;
            write_reg  <= grant_dest;
            commit_q   <= commit;
            sel_bad_q  <= sel_bad;
            if (commit) begin
                write_count <= write_count + 16'd1;
            end
        end else begin
            state <= IDLE;
        end
    end

    // Strobes are valid only in the cycle right after a grant.
    assign reg_write = (state == WRITE) && commit_q;
    assign sel_err   = (state == WRITE) && sel_bad_q;

endmodule

// File: doc/regwrite_scheduler.md
Name: regwrite_scheduler

Overview:
- Register-file write-port scheduler for the multicycle MIPS datapath.
- Several writeback requesters compete for the single register-file write port: ALU result, load, HI/LO moves, set-less-than and shift/immediate paths.
- The block grants one requester per cycle using round-robin arbitration.
- It drives the writeback mux select code, the destination register index and the RegWrite strobe. All three are registered, so each write appears one cycle after its grant.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- SEL_W, 4, width of the writeback mux select code.
- SEL_MAX, 10, highest legal select code; codes above it are illegal.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  freezes arbitration, e.g. during memory wait.
- req_valid  input  NUM_REQ  per-requester write request.
- req_dest  input  5*NUM_REQ  destination register index; requester i uses bits [5i+4:5i].
- req_sel  input  SEL_W*NUM_REQ  mux select code for requester i.
- req_grant  output  NUM_REQ  one-hot grant, combinational, same cycle as the accepted request.
- mem_to_reg  output  SEL_W  registered writeback mux select.
- write_reg  output  5  registered destination register index.
- reg_write  output  1  registered register-file write strobe.
- sel_err  output  1  registered one-cycle pulse on an illegal select code.
- write_count  output  16  count of committed writes; wraps modulo 2^16.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high.
- Reset values:
  - mem_to_reg=0, write_reg=0, reg_write=0, sel_err=0, write_count=0.
  - Round-robin pointer rr_ptr=0.
  - State=IDLE.
- Handshake:
  - A requester raises req_valid and holds req_valid, req_dest and req_sel stable until it sees req_grant high.
  - A transfer completes on the rising edge where req_valid[i] && req_grant[i].
  - Requester i may issue a new request in the very next cycle.
- Arbitration:
  - Grant goes to the first asserted req_valid, searching from index rr_ptr upward and wrapping modulo NUM_REQ.
  - At most one grant per cycle.
  - No grant while stall=1 or reset=1.
  - After a grant to i, rr_ptr becomes (i+1) mod NUM_REQ.
  - With no grant, rr_ptr holds its value.
- State machine (2 states):
  - IDLE: reg_write=0.
    - A grant moves the block to WRITE on the next cycle.
  - WRITE: outputs reflect the previous cycle's grant.
    - A new grant in this cycle keeps the block in WRITE. Back-to-back writes are allowed, giving one write per cycle sustained.
    - No grant returns the block to IDLE.
- Latency:
  - Grant in cycle N gives mem_to_reg, write_reg and reg_write valid in cycle N+1, held for exactly one cycle.
  - With no grant in N, reg_write=0 in N+1.
  - mem_to_reg and write_reg hold their last values when idle.
- Register $zero:
  - A granted request with dest=0 completes the handshake.
  - mem_to_reg and write_reg update, but reg_write stays 0 and write_count does not increment.
- Illegal select:
  - A granted request with sel>SEL_MAX is accepted, so the requester is not deadlocked.
  - reg_write stays 0, sel_err pulses 1 in N+1, write_count does not increment.
  - If dest=0 and sel is illegal, sel_err still pulses.
- write_count:
  - Increments at the same edge reg_write is set to 1.
  - 0xFFFF wraps to 0x0000.
- stall:
  - No grants while stall=1.
  - A write already registered (grant in the cycle before stall rose) still completes: reg_write=1 for its one cycle.
  - rr_ptr is frozen while stall=1.
- Simultaneous events:
  - reset dominates stall and all requests.
  - With reset=1, no grant is issued and the in-flight write is dropped: reg_write=0 on the next cycle.
  - Reset during WRITE returns the block to IDLE with all outputs at reset values.
- req_grant:
  - Depends only on rr_ptr, stall, reset and req_valid.
  - Has no combinational path from req_dest or req_sel.

Test Plan:
1. Reset then single request: req_valid=4'b0010, dest=5'd8, sel=4'd8 -> req_grant=4'b0010 in cycle N; in N+1 reg_write=1, write_reg=8, mem_to_reg=8; in N+2 reg_write=0; write_count=1.
2. Round-robin fairness: all four valid continuously from reset, dests 1..4 -> grants in order 0,1,2,3,0 on consecutive cycles; reg_write=1 every cycle from the second onward; write_count=4 after 5 cycles.
3. $zero and illegal select: req0 dest=0 sel=1 -> granted, reg_write=0, write_count unchanged. req1 dest=5 sel=4'd12 -> granted, sel_err=1 for one cycle, reg_write=0.
4. Stall: req2 valid, stall=1 for 3 cycles -> no grant, rr_ptr unchanged; stall=0 -> grant next cycle, write one cycle later. Grant in cycle N plus stall in N+1 -> reg_write still 1 in N+1.
5. Reset mid-operation: grant in cycle N, reset=1 in N+1 -> reg_write=0 in N+2, write_count=0, next grant searches from index 0.
6. Counter wrap: preload via 65535 committed writes, one more write -> write_count=0x0000.
